// File: rtl/scan_arbiter.sv
// scan_arbiter
//   Shares one serial-input scanner between N_REQ command handlers.
//   Arbitration is round-robin. Each grant produces one scanner request
//   pulse. The scanner type is held for the whole transaction. The scanner
//   result and its error flag go back to the winning handler, together with
//   a one-cycle ack. All outputs are registered.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   req_i   [N_REQ]    request levels from the handlers
//   type_i  [N_REQ]    per-handler type (0 = byte, 1 = word/address)
//   gnt_o   [N_REQ]    one-hot scanner owner; 0 when there is no owner
//   ack_o   [N_REQ]    one-cycle completion pulse to the owner
//   dout_o  [32]       scanner result, held until the next completion
//   flag_o             scanner error flag, held like dout_o
//   busy_o             high in every state except IDLE
//   req_rx_o           one-cycle request pulse to the scanner
//   type_rx_o          scanner type, stable from grant through DONE
//   ack_rx_i           scanner acknowledge (may stay high several cycles)
//   flag_rx_i, din_rx_i scanner flag/data, valid while ack_rx_i is high
module scan_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] type_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] ack_o,
    output logic [31:0]      dout_o,
    output logic             flag_o,
    output logic             busy_o,
    output logic             req_rx_o,
    output logic             type_rx_o,
    input  logic             ack_rx_i,
    input  logic             flag_rx_i,
    input  logic [31:0]      din_rx_i
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_COOL} state_t;

    state_t           state_q, state_d;
    // The last winner doubles as the current owner. Both are updated together
    // at grant time and stay unchanged until the next grant.
    logic [IW-1:0]    last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic [31:0]      dout_q, dout_d;
    logic             flag_q, flag_d, busy_q, busy_d;
    logic             req_rx_q, req_rx_d, type_rx_q, type_rx_d;

    // Round-robin pick: the first set request at last+1, last+2, .. (wrapping).
    // The offsets are scanned from far to near, so the nearest hit is written last and wins.
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    int            idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_i[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        ack_d     = ack_q;
        dout_d    = dout_q;
        flag_d    = flag_q;
        busy_d    = busy_q;
        req_rx_d  = req_rx_q;
        type_rx_d = type_rx_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    last_d           = pick_idx;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    type_rx_d        = type_i[pick_idx];
                    req_rx_d         = 1'b1;
                    busy_d           = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_rx_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (ack_rx_i) begin
                    dout_d         = din_rx_i;
                    flag_d         = flag_rx_i;
                    ack_d          = '0;
                    ack_d[last_q]  = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                ack_d   = '0;
                gnt_d   = '0;
                state_d = S_COOL;
            end
            S_COOL: begin
                // A scanner ack lasting several cycles must not be seen
                // again as the completion of a new transaction.
                if (!ack_rx_i) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            last_q    <= IW'(N_REQ - 1);
            gnt_q     <= '0;
            ack_q     <= '0;
            dout_q    <= '0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            req_rx_q  <= 1'b0;
            type_rx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
            req_rx_q  <= req_rx_d;
            type_rx_q <= type_rx_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign dout_o    = dout_q;
    assign flag_o    = flag_q;
    assign busy_o    = busy_q;
    assign req_rx_o  = req_rx_q;
    assign type_rx_o = type_rx_q;
endmodule

// File: tb/tb_scan_arbiter.sv
// Randomized bench for scan_arbiter. A transaction-level timeline model
// predicts each grant with round-robin arithmetic. Once a transaction starts,
// the model predicts every output from the grant time, the chosen scanner
// delay and the scanner ack length.
module tb_scan_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, typ, gnt, ack;
    logic [31:0]  dout, din_rx;
    logic         flag, busy, req_rx, type_rx, ack_rx, flag_rx;

    always #5 clk = ~clk;

    scan_arbiter #(.N_REQ(N)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .type_i(typ),
        .gnt_o(gnt), .ack_o(ack), .dout_o(dout), .flag_o(flag),
        .busy_o(busy), .req_rx_o(req_rx), .type_rx_o(type_rx),
        .ack_rx_i(ack_rx), .flag_rx_i(flag_rx), .din_rx_i(din_rx)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state.
    int          c = 0;        // sample index, one per clock edge
    bit          in_txn;       // a transaction is in progress
    int          last, own;    // round-robin pointer and current owner
    int          t_g, t_a, h, t_free;
    logic [31:0] m_dout, cur_din;
    logic        m_flag, m_type, cur_flag;

    function automatic int rr(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++)
            if (r[(l + k) % N]) return (l + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        in_txn = 0; last = N - 1; own = 0;
        m_dout = '0; m_flag = 1'b0; m_type = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_flag"}, flag, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_reqrx"}, req_rx, 0);
        chk({tag, "_typerx"}, type_rx, 0);
    endtask

    task automatic hard_reset();
        rst = 1'b1; req = '0; typ = '0; ack_rx = 1'b0; flag_rx = 1'b0; din_rx = '0;
        @(posedge clk); #1;
        check_zero("rst");
        model_reset();
        rst = 1'b0;
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        req = '0; ack_rx = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // mode 0: random requesters, owner may drop req mid-transaction
    // mode 1: req[0] and req[2] held permanently
    // mode 2: one burst of 1011, each requester drops req at its own ack
    // mode 3: only requester 0
    task automatic run(input int ncyc, input int mode, input bit rst_in_wait);
        logic [N-1:0] req_p, typ_p, oh, e_gnt, e_ack;
        logic [31:0]  rnd;
        bit           pend_rst;
        pend_rst = rst_in_wait;
        if (mode == 2) req = 4'b1011;
        for (int n = 0; n < ncyc; n++) begin
            req_p = req; typ_p = typ;
            @(posedge clk); #1;
            c++;
            if (!in_txn && req_p != '0) begin
                own    = rr(req_p, last);
                last   = own;
                in_txn = 1;
                t_g    = c;
                m_type = typ_p[own];
                t_a    = c + int'($urandom_range(4, 1));
                h      = int'($urandom_range(3, 1));
                t_free = ((h > 2) ? t_a + h : t_a + 2) + 1;
                cur_din  = $urandom;
                cur_flag = 1'($urandom_range(1, 0));
            end
            if (in_txn && c == t_a + 1) begin
                m_dout = cur_din; m_flag = cur_flag;
            end
            oh = '0;
            if (in_txn) oh[own] = 1'b1;
            e_gnt = (in_txn && c < t_a + 2) ? oh : '0;
            e_ack = (in_txn && c == t_a + 1) ? oh : '0;
            chk("gnt", gnt, e_gnt);
            chk("ack", ack, e_ack);
            chk("busy", busy, (in_txn && c < t_free) ? 1 : 0);
            chk("req_rx", req_rx, (in_txn && c == t_g) ? 1 : 0);
            chk("type_rx", type_rx, m_type);
            chk("dout", dout, m_dout);
            chk("flag", flag, m_flag);
            if (in_txn && c == t_free) in_txn = 0;

            if (pend_rst && in_txn && c == t_g + 1) begin
                pend_rst = 0;
                mid_reset();
                continue;
            end

            // Scanner: ack for h cycles starting at t_a. Outside a transaction,
            // a stray ack with junk data is sometimes driven, and must be ignored.
            if (in_txn && c >= t_a && c < t_a + h) begin
                ack_rx = 1'b1; din_rx = cur_din; flag_rx = cur_flag;
            end else begin
                ack_rx  = !in_txn && ($urandom_range(7, 0) == 0);
                din_rx  = $urandom;
                flag_rx = 1'($urandom_range(1, 0));
            end

            // Requesters
            for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
            case (mode)
                0: begin
                    for (int i = 0; i < N; i++)
                        if (!req[i] && $urandom_range(3, 0) == 0) req[i] = 1'b1;
                    if (in_txn && c > t_g && c < t_a && $urandom_range(5, 0) == 0)
                        req[own] = 1'b0;
                end
                1: begin req[0] = 1'b1; req[2] = 1'b1; end
                3: begin
                    if (!req[0] && $urandom_range(1, 0) == 1) req[0] = 1'b1;
                    req[N-1:1] = '0;
                end
                default: ;
            endcase
            rnd = $urandom;
            typ = rnd[N-1:0];
        end
    endtask

    initial begin
        hard_reset();
        run(30, 3, 1'b0);
        run(40, 3, 1'b1);
        hard_reset();
        run(50, 2, 1'b0);
        run(60, 1, 1'b0);
        run(600, 0, 1'b0);
        hard_reset();
        run(40, 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
